// File: rtl/amp_step_ctrl.sv
// amp_step_ctrl
// Controller for the power-of-two amplitude scale word M = 1 << exp.
// Three requesters compete for exp. In priority order they are:
//   - the external configuration port,
//   - the debounced UP/DOWN front-panel buttons, with auto-repeat,
//   - an automatic triangle sweep (7,6,..,0,1,..,7).
// Ports:
//   clk, rst_n          system clock (rising edge); async active-low reset
//   ce                  1 ms tick, one clk wide; gates button and sweep timing
//   btn_up/down/mode    raw asynchronous button levels, active-high
//   ext_req, ext_exp    external set request (held until ack) and its exponent
//   ext_ack             one-cycle acknowledge of an external request
//   M, exp              registered amplitude word and exponent
//   mode                0 = MANUAL, 1 = SWEEP
//   m_upd               one-cycle pulse in the first cycle M shows a new value
module amp_step_ctrl #(
  parameter int DEB_TICKS    = 4,
  parameter int REP_DELAY    = 50,
  parameter int REP_PERIOD   = 20,
  parameter int SWEEP_PERIOD = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  input  logic       ext_req,
  input  logic [2:0] ext_exp,
  output logic       ext_ack,
  output logic [7:0] M,
  output logic [2:0] exp,
  output logic       mode,
  output logic       m_upd
);

  localparam int B_UP = 0;
  localparam int B_DN = 1;
  localparam int B_MD = 2;

  localparam int DEB_W   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int SWP_W   = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_TICKS - 1);
  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
  localparam logic [REP_W-1:0] REP_LOAD_D = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0] REP_LOAD_P = REP_W'(REP_PERIOD);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
  localparam logic [SWP_W-1:0] SWP_LAST   = SWP_W'(SWEEP_PERIOD - 1);
  localparam logic [SWP_W-1:0] SWP_ONE    = SWP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } btn_st_t;

  // Saturating one-step move of the exponent.
  function automatic logic [2:0] step_exp(input logic [2:0] cur, input logic up);
    logic [2:0] res;
    if (up) begin
      res = (cur == 3'd7) ? cur : cur + 3'd1;
    end else begin
      res = (cur == 3'd0) ? cur : cur - 3'd1;
    end
    return res;
  endfunction

  logic [2:0]       w_btn_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_deb;
  logic [2:0]       r_deb_prev;
  logic [DEB_W-1:0] r_deb_cnt [3];
  logic [2:0]       w_press;

  logic             r_mode;
  logic             w_sweep_entry;

  btn_st_t          r_st;
  btn_st_t          w_st_nxt;
  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] w_rep_nxt;
  logic             r_held_up;
  logic             w_held_up_nxt;
  logic             w_held_lvl;
  logic             w_both;
  logic             w_btn_req;
  logic             w_btn_dir_up;

  logic [SWP_W-1:0] r_swp_cnt;
  logic             r_dir_up;
  logic             w_swp_tick;
  logic             w_swp_req;
  logic             w_swp_up;

  logic             w_ext_take;
  logic [2:0]       w_exp_nxt;
  logic [2:0]       r_exp;
  logic [7:0]       r_m;
  logic             r_m_upd;
  logic             r_ext_ack;

  assign w_btn_raw = {btn_mode, btn_down, btn_up};

  // A press is a debounced 0->1 edge, seen on the ce after the flip.
  assign w_press       = ce ? (r_deb & ~r_deb_prev) : 3'b000;
  assign w_sweep_entry = w_press[B_MD] & ~r_mode;

  // Two-flop synchronisers for the raw button levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: the level must disagree for DEB_TICKS consecutive ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb      <= 3'b000;
      r_deb_prev <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else if (ce) begin
      r_deb_prev <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_deb[i]     <= ~r_deb[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DEB_ONE;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Mode toggles on every btn_mode press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else begin
      r_mode <= r_mode ^ w_press[B_MD];
    end
  end

  assign w_held_lvl = r_held_up ? r_deb[B_UP] : r_deb[B_DN];
  assign w_both     = r_deb[B_UP] & r_deb[B_DN];

  // Button FSM state, repeat counter and held direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= ST_IDLE;
      r_rep     <= '0;
      r_held_up <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_rep     <= w_rep_nxt;
      r_held_up <= w_held_up_nxt;
    end
  end

  // Button FSM next state and step request; entering SWEEP forces IDLE.
  always_comb begin
    w_st_nxt      = r_st;
    w_rep_nxt     = r_rep;
    w_held_up_nxt = r_held_up;
    w_btn_req     = 1'b0;
    w_btn_dir_up  = r_held_up;
    if (w_sweep_entry) begin
      w_st_nxt  = ST_IDLE;
      w_rep_nxt = '0;
    end else if (ce && !r_mode) begin
      case (r_st)
        ST_IDLE: begin
          if (w_press[B_UP] && !r_deb[B_DN]) begin
            w_btn_req     = 1'b1;
            w_btn_dir_up  = 1'b1;
            w_held_up_nxt = 1'b1;
            w_rep_nxt     = REP_LOAD_D;
            w_st_nxt      = ST_DELAY;
          end else if (w_press[B_DN] && !r_deb[B_UP]) begin
            w_btn_req     = 1'b1;
            w_btn_dir_up  = 1'b0;
            w_held_up_nxt = 1'b0;
            w_rep_nxt     = REP_LOAD_D;
            w_st_nxt      = ST_DELAY;
          end else begin
            w_st_nxt = ST_IDLE;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!w_held_lvl || w_both) begin
            w_st_nxt  = ST_IDLE;
            w_rep_nxt = '0;
          end else if (r_rep == REP_ONE) begin
            // Counter is about to reach zero: step and start the next period.
            w_btn_req = 1'b1;
            w_rep_nxt = REP_LOAD_P;
            w_st_nxt  = ST_REPEAT;
          end else begin
            w_rep_nxt = r_rep - REP_ONE;
          end
        end
        default: begin
          w_st_nxt  = ST_IDLE;
          w_rep_nxt = '0;
        end
      endcase
    end else begin
      w_st_nxt = r_st;
    end
  end

  // The ce that leaves SWEEP must not produce a sweep step.
  assign w_swp_tick = ce & r_mode & ~w_press[B_MD];
  assign w_swp_req  = w_swp_tick & (r_swp_cnt == SWP_LAST);
  // Reverse at the ends so the sweep traces a triangle.
  assign w_swp_up   = r_dir_up ? (r_exp != 3'd7) : (r_exp == 3'd0);

  // Sweep period counter and direction; counter reloads even if the step loses arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_swp_cnt <= '0;
      r_dir_up  <= 1'b0;
    end else if (w_sweep_entry) begin
      r_swp_cnt <= '0;
    end else if (w_swp_tick) begin
      if (w_swp_req) begin
        r_swp_cnt <= '0;
        r_dir_up  <= w_swp_up;
      end else begin
        r_swp_cnt <= r_swp_cnt + SWP_ONE;
      end
    end
  end

  assign w_ext_take = ext_req & ~r_ext_ack;

  // Arbitration: ext beats button beats sweep.
  always_comb begin
    w_exp_nxt = r_exp;
    if (w_ext_take) begin
      w_exp_nxt = ext_exp;
    end else if (w_btn_req) begin
      w_exp_nxt = step_exp(r_exp, w_btn_dir_up);
    end else if (w_swp_req) begin
      w_exp_nxt = step_exp(r_exp, w_swp_up);
    end else begin
      w_exp_nxt = r_exp;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp     <= 3'd7;
      r_m       <= 8'h80;
      r_m_upd   <= 1'b0;
      r_ext_ack <= 1'b0;
    end else begin
      r_exp     <= w_exp_nxt;
      r_m       <= 8'd1 << w_exp_nxt;
      r_m_upd   <= (w_exp_nxt != r_exp);
      r_ext_ack <= w_ext_take;
    end
  end

  assign exp     = r_exp;
  assign M       = r_m;
  assign m_upd   = r_m_upd;
  assign ext_ack = r_ext_ack;
  assign mode    = r_mode;

endmodule

// File: doc/amp_step_ctrl.md
# amp_step_ctrl

Controller for the output-amplitude scale register. It arbitrates three requesters for the power-of-two amplitude word M: an external configuration port, the front-panel UP/DOWN buttons (debounced, with auto-repeat), and an automatic triangle sweep. It holds M as a 3-bit exponent, so M = 1<<exp is always in the range 0x01..0x80, and it drives M to the amplitude multiplier in the signal datapath.

## Interface
- DEB_TICKS, 4: number of consecutive ce ticks a raw button level must hold before the debounced level follows it (>=1).
- REP_DELAY, 50: ce ticks from the first step to the first auto-repeat step (>=1).
- REP_PERIOD, 20: ce ticks between subsequent auto-repeat steps (>=1).
- SWEEP_PERIOD, 100: ce ticks per sweep step (>=1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  1 ms tick, one clk wide; gates all button and sweep timing.
- btn_up, btn_down, btn_mode  in  1 each  raw asynchronous button levels, active-high.
- ext_req  in  1  external set request; held until ext_ack is seen.
- ext_exp  in  3  exponent requested by the external port; must be stable while ext_req is high.
- ext_ack  out  1  one-cycle acknowledge.
- M  out  8  amplitude word, registered, equal to 1<<exp.
- exp  out  3  current exponent, registered.
- mode  out  1  0 = MANUAL, 1 = SWEEP.
- m_upd  out  1  one-cycle pulse in the first cycle M shows a new value.

## Operation
- **Reset (async):** exp=7, M=0x80, mode=0, sweep dir=down, button FSM=IDLE. All counters, debounced levels, ext_ack and m_upd are 0.
- **Synchronisers:** each button passes through a 2-flop synchroniser on clk.
- **Debounce (per button, on ce only):**
  - The counter increments while the synchronised level differs from the debounced level, and clears when they match.
  - On the ce where the counter reaches DEB_TICKS-1 and the levels still differ, the debounced level flips and the counter clears.
  - A press event is a debounced 0->1 transition. It is detected on the ce following the flip.
- **Mode:** a btn_mode press event toggles mode.
  - On entry to SWEEP: button FSM goes to IDLE and the sweep counter clears.
  - On exit from SWEEP: the sweep counter stops and exp holds.
- **Button FSM (MANUAL only, evaluated on ce):**
  - IDLE: an up press event with debounced down=0 (or the mirror case) requests one step in that direction, loads the repeat counter with REP_DELAY and moves to DELAY.
  - DELAY: the counter decrements each ce. On reaching 0 it requests a step, reloads REP_PERIOD and moves to REPEAT.
  - REPEAT: the counter decrements each ce. On reaching 0 it requests a step and reloads REP_PERIOD.
  - From DELAY or REPEAT: release of the held button, or both buttons debounced high, returns the FSM to IDLE with no step. If both buttons become high in IDLE, no step is taken.
  - In SWEEP mode, up/down presses are ignored.
- **Sweep (SWEEP only):**
  - The counter counts ce ticks. At SWEEP_PERIOD-1 it wraps to 0 and requests a step in dir.
  - If exp==7 with dir up, dir flips to down first, and vice versa at exp==0. The result is the triangle 7,6,…,0,1,…,7.
- **Stepping:** up means exp+1 and down means exp-1. Both saturate: up at 7 and down at 0 leave exp unchanged with no m_upd.
- **Arbitration, applied per clk cycle:**
  - Priority order is ext > button > sweep.
  - ext_req is sampled on every clk, independent of ce. When ext_req=1 and ext_ack=0, exp takes ext_exp and ext_ack=1 in the next cycle.
  - A button or sweep step requested in the same cycle is discarded. Its counters still reload as if the step had been taken.
  - While ext_ack=1, ext_req is ignored. The requester drops ext_req on seeing ext_ack.
- **m_upd:** asserted for one cycle whenever exp changes value. It is not asserted for an ext write of the current exponent.

## Timing
- exp, M and m_upd update on the same clk edge that consumes the request.
  - For button and sweep steps, that is the edge ending the ce cycle.
  - For ext, that is the edge after ext_req is sampled, coincident with ext_ack rising.
- Button latency: 2 clk (synchroniser), then M changes at the end of the (DEB_TICKS+1)-th ce pulse after the synchronised level rises.
- Auto-repeat step spacing: exactly REP_DELAY ce, then REP_PERIOD ce.
- Sweep step spacing: exactly SWEEP_PERIOD ce. The first step comes SWEEP_PERIOD ce after entry.
- ext_ack is high for exactly 1 cycle per request. Minimum ext request spacing is 2 cycles.
- Reset asserted mid-operation takes effect immediately. Outputs return to reset values asynchronously.

## Test plan
- Release reset: M=0x80, exp=7, mode=0, m_upd=0, ext_ack=0. Then apply a btn_up press: no m_upd (saturated).
- DEB_TICKS=4: a 2-ce btn_down glitch gives no change. btn_down held: M=0x40 at the end of the 5th ce, with one m_upd pulse.
- REP_DELAY=50, REP_PERIOD=20, btn_down held: M goes 0x40 (t0), 0x20 (t0+50 ce), 0x10 (+20), … down to 0x01, then no further m_upd. btn_up+btn_down together produce no step.
- Toggle to SWEEP with SWEEP_PERIOD=10 from M=0x80: M goes 0x40, 0x20, …, 0x01, 0x02, …, at 10-ce spacing. Toggling back freezes M.
- ext_req with ext_exp=3 in the same cycle as a sweep step: M=0x08, ext_ack high for 1 cycle, sweep step lost, next sweep step 10 ce later.
- Assert rst_n low in the middle of REPEAT: M=0x80 immediately. After release, no step occurs until a new debounced press.
